// File: rtl/comp_ingress_arbiter_pkg.sv
// Shared constants and types for the compression ingress arbiter.
// Imported by the interface, the rr_pick sub-module and the top.
package comp_pkg;

    localparam int COMP_NUM_SRC = 4;
    localparam int COMP_DATA_W  = 256;
    localparam int COMP_KEEP_W  = COMP_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        XFER
    } arb_state_t;

    // index width that never collapses to zero bits
    function automatic int comp_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comp_ingress_arbiter_if.sv
// AXI-Stream bundle carrying N packed lanes of tdata/tkeep/tvalid/tlast/tready.
// The ingress side uses N sources; the frontend side uses a single lane.
interface comp_ingress_arbiter_if
    import comp_pkg::*;
#(
    parameter int N      = 1,
    parameter int DATA_W = COMP_DATA_W,
    parameter int KEEP_W = DATA_W / 8
);

    logic [N*DATA_W-1:0] tdata;
    logic [N*KEEP_W-1:0] tkeep;
    logic [N-1:0]        tvalid;
    logic [N-1:0]        tlast;
    logic [N-1:0]        tready;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/comp_ingress_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping mod NUM_SRC (rotate, priority-encode, rotate back).
module rr_pick
    import comp_pkg::*;
#(
    parameter  int NUM_SRC = COMP_NUM_SRC,
    localparam int IDX_W   = comp_idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;

    // rotate so ptr sits at bit 0, take lowest set bit, add ptr back
    always_comb begin
        dbl   = {req, req};
        rot   = dbl[ptr +: NUM_SRC];
        found = |rot;
        off   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(NUM_SRC)) begin
            sum = sum - (IDX_W + 1)'(NUM_SRC);
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/comp_ingress_arbiter.sv
// Packet-atomic round-robin arbiter feeding one compression frontend.
// Optional per-packet beat watchdog: define COMP_ARB_WATCHDOG_EN.
module comp_ingress_arbiter
    import comp_pkg::*;
#(
    parameter  int NUM_SRC       = COMP_NUM_SRC,
    parameter  int DATA_W        = COMP_DATA_W,
    parameter  int MAX_PKT_BEATS = 64,
    localparam int KEEP_W        = DATA_W / 8,
    localparam int IDX_W         = comp_idx_w(NUM_SRC)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    comp_ingress_arbiter_if.slave  s,
    comp_ingress_arbiter_if.master m,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   busy,
    output logic                   err_timeout
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] grant_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] ptr_next;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             sel_valid;
    logic             sel_last;
    logic             force_last;
    logic             accept;

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req   (s.tvalid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign m.tdata   = s.tdata[int'(grant_q)*DATA_W +: DATA_W];
    assign m.tkeep   = s.tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
    assign sel_valid = s.tvalid[grant_q];
    assign sel_last  = s.tlast[grant_q];
    assign grant_id  = grant_q;

    // the source that just finished drops to lowest priority
    assign ptr_next = (grant_q == IDX_W'(NUM_SRC - 1))
                    ? '0 : grant_q + 1'b1;

    assign accept = (state_q == XFER) && sel_valid && m.tready[0];

`ifdef COMP_ARB_WATCHDOG_EN
    logic [7:0] beat_q;
    logic       err_q;

    assign force_last = (beat_q == 8'(MAX_PKT_BEATS - 1)) && !sel_last;
    assign err_timeout = err_q;

    // beats per grant; sticky flag when a packet is cut short
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == ARB) begin
                beat_q <= '0;
            end else if (accept) begin
                beat_q <= beat_q + 8'd1;
            end
            if (accept && force_last) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = ^MAX_PKT_BEATS;
    assign force_last  = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // state, grant and round-robin pointer registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // next state and handshake steering; grant held until the last beat
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        busy     = 1'b0;
        m.tvalid = '0;
        m.tlast  = '0;
        s.tready = '0;
        unique case (state_q)
            IDLE: begin
                if (|s.tvalid) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = XFER;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                busy              = 1'b1;
                m.tvalid[0]       = sel_valid;
                m.tlast[0]        = sel_last | force_last;
                s.tready[grant_q] = m.tready[0];
                if (accept && (sel_last || force_last)) begin
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_comp_ingress_arbiter.sv
// Self-checking bench for comp_ingress_arbiter with a queue-based
// round-robin packet model; follows COMP_ARB_WATCHDOG_EN if defined.
`timescale 1ns/1ps
module tb_comp_ingress_arbiter;
    import comp_pkg::*;

    localparam int NS   = 4;
    localparam int DW   = 256;
    localparam int KW   = DW / 8;
    localparam int MAXB = 4;
    localparam int IW   = 2;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic          err_timeout;

    always #5 aclk = ~aclk;

    comp_ingress_arbiter_if #(.N(NS), .DATA_W(DW)) s_if ();
    comp_ingress_arbiter_if #(.N(1),  .DATA_W(DW)) m_if ();

    comp_ingress_arbiter #(
        .NUM_SRC       (NS),
        .DATA_W        (DW),
        .MAX_PKT_BEATS (MAXB)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s           (s_if.slave),
        .m           (m_if.master),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        beat_t b;
        int    src;
        int    cyc;
    } obs_t;

    beat_t src_q[NS][$];
    obs_t  mon_q[$];
    beat_t exp_b[$];
    int    exp_s[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    rdy_mode = 0;

    function automatic beat_t rand_beat(input logic last);
        beat_t b;
        for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom;
        b.k = $urandom;
        b.l = last;
        return b;
    endfunction

    task automatic add_pkt(input int src, input int len);
        for (int i = 0; i < len; i++)
            src_q[src].push_back(rand_beat(i == len - 1));
    endtask

    // Reference: whole packets granted round-robin from pointer 0,
    // optionally cut after MAXB beats with the remainder re-queued.
    function automatic void model_build();
        beat_t q[NS][$];
        beat_t b;
        int    p = 0;
        int    s;
        int    n;
        bit    last;
        exp_b.delete();
        exp_s.delete();
        for (int i = 0; i < NS; i++) q[i] = src_q[i];
        forever begin
            s = -1;
            for (int k = 0; k < NS; k++)
                if (s < 0 && q[(p + k) % NS].size() > 0) s = (p + k) % NS;
            if (s < 0) break;
            n = 0;
            last = 1'b0;
            while (!last && q[s].size() > 0) begin
                b = q[s].pop_front();
                n++;
`ifdef COMP_ARB_WATCHDOG_EN
                if (!b.l && n == MAXB) b.l = 1'b1;
`endif
                last = b.l;
                exp_b.push_back(b);
                exp_s.push_back(s);
            end
            p = (s + 1) % NS;
        end
    endfunction

    // source drivers, frontend ready, and output beat recorder
    initial begin : drv
        logic [NS-1:0] acc;
        obs_t o;
        s_if.tvalid = '0;
        s_if.tlast  = '0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        m_if.tready = 1'b1;
        forever begin
            @(negedge aclk);
            cyc++;
            acc = aresetn ? (s_if.tvalid & s_if.tready) : '0;
            if (aresetn && m_if.tvalid[0] && m_if.tready[0]) begin
                o.b.d = m_if.tdata;
                o.b.k = m_if.tkeep;
                o.b.l = m_if.tlast[0];
                o.src = int'(grant_id);
                o.cyc = cyc;
                mon_q.push_back(o);
            end
            @(posedge aclk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                s_if.tvalid[i] = (src_q[i].size() > 0);
                s_if.tlast[i]  = 1'b0;
                if (src_q[i].size() > 0) begin
                    s_if.tdata[i*DW +: DW] = src_q[i][0].d;
                    s_if.tkeep[i*KW +: KW] = src_q[i][0].k;
                    s_if.tlast[i]          = src_q[i][0].l;
                end
            end
            case (rdy_mode)
                0:       m_if.tready[0] = 1'b1;
                1:       m_if.tready[0] = ~m_if.tready[0];
                default: m_if.tready[0] = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        for (int i = 0; i < NS; i++) src_q[i].delete();
        mon_q.delete();
        rdy_mode = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int t = 0;
        while (mon_q.size() < n && t < budget) begin
            @(negedge aclk);
            t++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge aclk);
        checks++;
        if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: tvalid %b tlast %b busy %b, want 0 0 0",
                     m_if.tvalid, m_if.tlast, busy);
        end
        checks++;
        if (grant_id !== '0 || s_if.tready !== '0) begin
            errors++;
            $display("FAIL reset_grant: grant %0d tready %b, want 0 0000",
                     grant_id, s_if.tready);
        end
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: err_timeout %b, want 0", err_timeout);
        end
    endtask

    task automatic test_single_source();
        do_reset();
        add_pkt(2, 3);
        model_build();
        wait_beats(1, 50);
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL single_grant: busy %b grant %0d, want 1 2", busy, grant_id);
        end
        wait_beats(3, 50);
        @(negedge aclk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_end: busy %b, want 0", busy);
        end
        checks++;
        if (mon_q.size() != exp_b.size()) begin
            errors++;
            $display("FAIL single_count: got %0d beats, want %0d",
                     mon_q.size(), exp_b.size());
        end
        for (int i = 0; i < exp_b.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].b !== exp_b[i] || mon_q[i].src != exp_s[i]) begin
                errors++;
                $display("FAIL single_beat %0d: got src %0d last %b data %h want src %0d last %b data %h",
                         i, mon_q[i].src, mon_q[i].b.l, mon_q[i].b.d,
                         exp_s[i], exp_b[i].l, exp_b[i].d);
            end
        end
    endtask

    task automatic test_all_sources();
        int order[5] = '{0, 1, 2, 3, 0};
        int starts[$];
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NS; s++) add_pkt(s, 2);
        model_build();
        wait_beats(exp_b.size(), 300);
        repeat (6) @(negedge aclk);
        checks++;
        if (mon_q.size() != exp_b.size()) begin
            errors++;
            $display("FAIL all_count: got %0d beats, want %0d",
                     mon_q.size(), exp_b.size());
        end
        for (int i = 0; i < exp_b.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].b !== exp_b[i] || mon_q[i].src != exp_s[i]) begin
                errors++;
                $display("FAIL all_beat %0d: got src %0d last %b data %h want src %0d last %b data %h",
                         i, mon_q[i].src, mon_q[i].b.l, mon_q[i].b.d,
                         exp_s[i], exp_b[i].l, exp_b[i].d);
            end
        end
        for (int i = 0; i < mon_q.size(); i++)
            if (i == 0 || mon_q[i-1].b.l) starts.push_back(mon_q[i].src);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= starts.size() || starts[i] != order[i]) begin
                errors++;
                $display("FAIL all_order %0d: got src %0d, want %0d", i,
                         (i < starts.size()) ? starts[i] : -1, order[i]);
            end
        end
    endtask

    task automatic test_stall();
        int             t = 0;
        int             stalls = 0;
        bit             stalled = 1'b0;
        bit             others = 1'b0;
        logic [DW-1:0]  pd = '0;
        do_reset();
        rdy_mode = 1;
        add_pkt(1, 6);
        model_build();
        while (mon_q.size() < 6 && t < 200) begin
            @(negedge aclk);
            t++;
            if (!others && busy) begin
                add_pkt(0, 2);
                add_pkt(2, 2);
                add_pkt(3, 2);
                others = 1'b1;
            end
            checks++;
            if ((s_if.tready & 4'b1101) !== 4'b0000) begin
                errors++;
                $display("FAIL stall_tready: got %b, want 0 on sources 0,2,3",
                         s_if.tready);
            end
            if (stalled) begin
                checks++;
                if (m_if.tdata !== pd) begin
                    errors++;
                    $display("FAIL stall_data: got %h, want %h", m_if.tdata, pd);
                end
            end
            stalled = m_if.tvalid[0] && !m_if.tready[0];
            pd = m_if.tdata;
            if (stalled) stalls++;
        end
        checks++;
        if (stalls == 0 || mon_q.size() < 6) begin
            errors++;
            $display("FAIL stall_seen: got %0d stalls %0d beats, want >0 and 6",
                     stalls, mon_q.size());
        end
        for (int i = 0; i < 6 && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].b !== exp_b[i] || mon_q[i].src != 1) begin
                errors++;
                $display("FAIL stall_beat %0d: got src %0d data %h, want src 1 data %h",
                         i, mon_q[i].src, mon_q[i].b.d, exp_b[i].d);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int p = 0; p < 4; p++) add_pkt(3, 1);
        model_build();
        wait_beats(4, 100);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= mon_q.size() || mon_q[i].b !== exp_b[i] || mon_q[i].src != 3) begin
                errors++;
                $display("FAIL b2b_beat %0d: got %0d beats, want src 3 beat match",
                         i, mon_q.size());
            end
        end
        for (int i = 1; i < 4 && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].cyc - mon_q[i-1].cyc != 3) begin
                errors++;
                $display("FAIL b2b_gap %0d: got %0d cycles, want 3",
                         i, mon_q[i].cyc - mon_q[i-1].cyc);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        add_pkt(2, 5);
        wait_beats(1, 50);
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (m_if.tvalid !== 1'b0 || s_if.tready !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_out: tvalid %b tready %b busy %b, want 0",
                     m_if.tvalid, s_if.tready, busy);
        end
        for (int i = 0; i < NS; i++) src_q[i].delete();
        @(negedge aclk);
        mon_q.delete();
        aresetn = 1'b1;
        checks++;
        if (grant_id !== '0) begin
            errors++;
            $display("FAIL rst_mid_grant: got %0d, want 0", grant_id);
        end
        add_pkt(2, 2);
        add_pkt(0, 2);
        model_build();
        wait_beats(4, 100);
        checks++;
        if (mon_q.size() < 4 || mon_q[0].src != 0) begin
            errors++;
            $display("FAIL rst_mid_first: got %0d beats first src %0d, want 4 and 0",
                     mon_q.size(), (mon_q.size() > 0) ? mon_q[0].src : -1);
        end
        for (int i = 0; i < exp_b.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].b !== exp_b[i] || mon_q[i].src != exp_s[i]) begin
                errors++;
                $display("FAIL rst_mid_beat %0d: got src %0d data %h, want src %0d data %h",
                         i, mon_q[i].src, mon_q[i].b.d, exp_s[i], exp_b[i].d);
            end
        end
    endtask

    task automatic test_watchdog();
`ifdef COMP_ARB_WATCHDOG_EN
        logic exp_err = 1'b1;
        int   exp_gap = 3;
`else
        logic exp_err = 1'b0;
        int   exp_gap = 1;
`endif
        do_reset();
        @(negedge aclk);
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wd_err_init: got %b, want 0", err_timeout);
        end
        add_pkt(0, 6);
        model_build();
        wait_beats(6, 100);
        repeat (4) @(negedge aclk);
        checks++;
        if (mon_q.size() != 6) begin
            errors++;
            $display("FAIL wd_count: got %0d beats, want 6", mon_q.size());
        end
        for (int i = 0; i < 6 && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i].b !== exp_b[i] || mon_q[i].src != 0) begin
                errors++;
                $display("FAIL wd_beat %0d: got src %0d last %b data %h want src 0 last %b data %h",
                         i, mon_q[i].src, mon_q[i].b.l, mon_q[i].b.d,
                         exp_b[i].l, exp_b[i].d);
            end
        end
        if (mon_q.size() >= 5) begin
            checks++;
            if (mon_q[4].cyc - mon_q[3].cyc != exp_gap) begin
                errors++;
                $display("FAIL wd_gap: got %0d cycles, want %0d",
                         mon_q[4].cyc - mon_q[3].cyc, exp_gap);
            end
        end
        checks++;
        if (err_timeout !== exp_err) begin
            errors++;
            $display("FAIL wd_err: got %b, want %b", err_timeout, exp_err);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_reset();
            rdy_mode = 2;
            for (int s = 0; s < NS; s++) begin
                int npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) add_pkt(s, $urandom_range(1, 6));
            end
            model_build();
            wait_beats(exp_b.size(), 3000);
            repeat (8) @(negedge aclk);
            checks++;
            if (mon_q.size() != exp_b.size()) begin
                errors++;
                $display("FAIL rand_count r%0d: got %0d beats, want %0d",
                         r, mon_q.size(), exp_b.size());
            end
            for (int i = 0; i < exp_b.size() && i < mon_q.size(); i++) begin
                checks++;
                if (mon_q[i].b !== exp_b[i] || mon_q[i].src != exp_s[i]) begin
                    errors++;
                    $display("FAIL rand_beat r%0d %0d: got src %0d last %b data %h want src %0d last %b data %h",
                             r, i, mon_q[i].src, mon_q[i].b.l, mon_q[i].b.d,
                             exp_s[i], exp_b[i].l, exp_b[i].d);
                end
            end
        end
    endtask

    initial begin : guard
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        test_reset();
        test_single_source();
        test_all_sources();
        test_stall();
        test_back_to_back();
        test_reset_mid_packet();
        test_watchdog();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
